// File: rtl/p12_pkg.sv
// rtl/p12_pkg.sv - shared widths, register addresses and decode helper for bus_target12
// Purpose: constants used by bus_target12 and p12_timer.
//   WORD_W / ADDR_W   : data and address widths of the 12-bit processor bus
//   *_ADDR            : memory-mapped register addresses
//   CTRL_*_BIT        : bit positions inside TIMER_CTRL
//   sel_e/decode_reg  : register-window decode (RAM range is checked by the top)
package p12_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 24;

  localparam logic [ADDR_W-1:0] TIMER_LOAD_ADDR  = 24'hFFFF00;
  localparam logic [ADDR_W-1:0] TIMER_CTRL_ADDR  = 24'hFFFF01;
  localparam logic [ADDR_W-1:0] IRQ_PEND_ADDR    = 24'hFFFF02;
  localparam logic [ADDR_W-1:0] IRQ_MASK_ADDR    = 24'hFFFF03;
  localparam logic [ADDR_W-1:0] TIMER_COUNT_ADDR = 24'hFFFF04;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LOAD,
    SEL_CTRL,
    SEL_PEND,
    SEL_MASK,
    SEL_COUNT
  } sel_e;

  function automatic sel_e decode_reg(input logic [ADDR_W-1:0] a);
    case (a)
      TIMER_LOAD_ADDR:  return SEL_LOAD;
      TIMER_CTRL_ADDR:  return SEL_CTRL;
      IRQ_PEND_ADDR:    return SEL_PEND;
      IRQ_MASK_ADDR:    return SEL_MASK;
      TIMER_COUNT_ADDR: return SEL_COUNT;
      default:          return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/p12_timer.sv
// rtl/p12_timer.sv - countdown timer with one-shot / auto-reload
// Purpose: 12-bit down counter that expires one cycle after reaching zero.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   load_we_i     : write strobe for TIMER_LOAD (also loads count)
//   ctrl_we_i     : write strobe for TIMER_CTRL (EN, AUTO)
//   wdata_i       : write data for either strobe
//   load_o        : TIMER_LOAD register
//   en_o, auto_o  : TIMER_CTRL bits
//   count_o       : current count
//   expire_o      : combinational pulse, high in the cycle the count expires
module p12_timer
  import p12_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we_i,
  input  logic              ctrl_we_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic              en_o,
  output logic              auto_o,
  output logic [WORD_W-1:0] count_o,
  output logic              expire_o
);

  logic [WORD_W-1:0] load_q, load_d;
  logic [WORD_W-1:0] count_q, count_d;
  logic              en_q, en_d;
  logic              auto_q, auto_d;
  logic              run;

  // Any timer register write freezes the countdown for that edge.
  assign run      = en_q && !load_we_i && !ctrl_we_i;
  assign expire_o = run && (count_q == '0);

  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    en_d    = en_q;
    auto_d  = auto_q;
    if (load_we_i) begin
      load_d  = wdata_i;
      count_d = wdata_i;
    end else if (ctrl_we_i) begin
      en_d   = wdata_i[CTRL_EN_BIT];
      auto_d = wdata_i[CTRL_AUTO_BIT];
    end else if (run) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else begin
        count_d = load_q;
        en_d    = auto_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q  <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
    end
  end

  assign load_o  = load_q;
  assign en_o    = en_q;
  assign auto_o  = auto_q;
  assign count_o = count_q;

endmodule

// File: rtl/bus_target12.sv
// rtl/bus_target12.sv - 12-bit processor bus target: RAM, timer and interrupt controller
// Purpose: single-cycle bus slave with RAM, timer registers and 24-bit interrupt output.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   req, we           : transfer strobe and direction (1 = write)
//   address, wdata    : word address and write data
//   rdata, rvalid     : read response, one cycle after the read is accepted
//   irq_src           : external rising-edge interrupt sources
//   irq               : pending & mask (bit 0 timer, bits 1..IRQ_EXT external)
module bus_target12
  import p12_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int IRQ_EXT   = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               we,
  input  logic [ADDR_W-1:0]  address,
  input  logic [WORD_W-1:0]  wdata,
  output logic [WORD_W-1:0]  rdata,
  output logic               rvalid,
  input  logic [IRQ_EXT-1:0] irq_src,
  output logic [23:0]        irq
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  sel_e sel;
  logic wr, rd;

  assign sel = (address[ADDR_W-1:RAM_AW] == '0) ? SEL_RAM : decode_reg(address);
  assign wr  = req && we;
  assign rd  = req && !we;

  logic [WORD_W-1:0] tmr_load, tmr_count;
  logic              tmr_en, tmr_auto, tmr_expire;

  p12_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_we_i (wr && (sel == SEL_LOAD)),
    .ctrl_we_i (wr && (sel == SEL_CTRL)),
    .wdata_i   (wdata),
    .load_o    (tmr_load),
    .en_o      (tmr_en),
    .auto_o    (tmr_auto),
    .count_o   (tmr_count),
    .expire_o  (tmr_expire)
  );

  // Single-port synchronous RAM, contents intentionally not reset.
  logic [WORD_W-1:0] mem [RAM_WORDS];
  logic [WORD_W-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (wr && (sel == SEL_RAM)) mem[address[RAM_AW-1:0]] <= wdata;
    if (rd && (sel == SEL_RAM)) ram_q <= mem[address[RAM_AW-1:0]];
  end

  logic [WORD_W-1:0]  reg_q, reg_d;
  logic               ram_sel_q, ram_sel_d;
  logic               rvalid_q, rvalid_d;
  logic [23:0]        pend_q, pend_d;
  logic [WORD_W-1:0]  mask_q, mask_d;
  logic [IRQ_EXT-1:0] src_q;
  logic [23:0]        set_vec, w1c_vec;

  always_comb begin
    reg_d     = reg_q;
    ram_sel_d = ram_sel_q;
    rvalid_d  = rd;
    mask_d    = mask_q;
    set_vec   = '0;
    w1c_vec   = '0;

    // rdata source only changes on a read so it holds between responses.
    if (rd) begin
      ram_sel_d = (sel == SEL_RAM);
      case (sel)
        SEL_LOAD:  reg_d = tmr_load;
        SEL_CTRL:  reg_d = {{(WORD_W-2){1'b0}}, tmr_auto, tmr_en};
        SEL_PEND:  reg_d = pend_q[WORD_W-1:0];
        SEL_MASK:  reg_d = mask_q;
        SEL_COUNT: reg_d = tmr_count;
        default:   reg_d = '0;
      endcase
    end

    if (wr && (sel == SEL_MASK)) mask_d = wdata;
    if (wr && (sel == SEL_PEND)) w1c_vec[WORD_W-1:0] = wdata;

    // Edge is the raw input rising against its registered copy.
    set_vec[0]         = tmr_expire;
    set_vec[IRQ_EXT:1] = irq_src & ~src_q;

    // Set is applied after clear so a simultaneous set wins.
    pend_d = (pend_q & ~w1c_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q     <= '0;
      ram_sel_q <= 1'b0;
      rvalid_q  <= 1'b0;
      pend_q    <= '0;
      mask_q    <= '0;
      src_q     <= '0;
    end else begin
      reg_q     <= reg_d;
      ram_sel_q <= ram_sel_d;
      rvalid_q  <= rvalid_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      src_q     <= irq_src;
    end
  end

  assign rdata  = ram_sel_q ? ram_q : reg_q;
  assign rvalid = rvalid_q;
  assign irq    = pend_q & {12'hFFF, mask_q};

endmodule

// File: tb/tb_bus_target12.sv
// tb/tb_bus_target12.sv - directed self-checking bench for bus_target12
module tb_bus_target12;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [23:0] address;
  logic [11:0] wdata;
  logic [11:0] rdata;
  logic        rvalid;
  logic [22:0] irq_src;
  logic [23:0] irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [23:0] A_LOAD  = 24'hFFFF00;
  localparam logic [23:0] A_CTRL  = 24'hFFFF01;
  localparam logic [23:0] A_PEND  = 24'hFFFF02;
  localparam logic [23:0] A_MASK  = 24'hFFFF03;
  localparam logic [23:0] A_COUNT = 24'hFFFF04;

  bus_target12 dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .address (address),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .irq_src (irq_src),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; the transfer is taken at the following posedge.
  task automatic do_write(input logic [23:0] a, input logic [11:0] d);
    req = 1'b1; we = 1'b1; address = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic do_read(input logic [23:0] a, output logic [11:0] d, output logic v);
    req = 1'b1; we = 1'b0; address = a;
    @(negedge clk);
    req = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic test_reset;
    rst = 1'b0; req = 1'b0; we = 1'b0; address = '0; wdata = '0; irq_src = '0;
    #1;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", rvalid); else pass_cnt++;
    total_cnt++; if (rdata !== 12'h000) $display("FAIL reset_rdata: got %h expected 000", rdata); else pass_cnt++;
    total_cnt++; if (irq !== 24'h0) $display("FAIL reset_irq: got %h expected 000000", irq); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL reset_release_rvalid: got %b expected 0", rvalid); else pass_cnt++;
  endtask

  task automatic test_ram;
    logic [11:0] d; logic v;
    do_write(24'h000010, 12'h5A5);
    do_read(24'h000010, d, v);
    total_cnt++; if (v !== 1'b1) $display("FAIL ram_rvalid: got %b expected 1", v); else pass_cnt++;
    total_cnt++; if (d !== 12'h5A5) $display("FAIL ram_rdata: got %h expected 5a5", d); else pass_cnt++;
    do_write(24'h0000FF, 12'hABC);
    do_read(24'h0000FF, d, v);
    total_cnt++; if (d !== 12'hABC || v !== 1'b1) $display("FAIL ram_top_word: got %h/%b expected abc/1", d, v); else pass_cnt++;
    do_read(24'h000010, d, v);
    total_cnt++; if (d !== 12'h5A5) $display("FAIL ram_keep: got %h expected 5a5", d); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (rvalid !== 1'b0 || rdata !== 12'h5A5) $display("FAIL ram_hold: got %h/%b expected 5a5/0", rdata, rvalid); else pass_cnt++;
  endtask

  task automatic test_unmapped;
    logic [11:0] d; logic v;
    do_read(24'h123456, d, v);
    total_cnt++; if (v !== 1'b1 || d !== 12'h000) $display("FAIL unmapped_read: got %h/%b expected 000/1", d, v); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL unmapped_idle: got %b expected 0", rvalid); else pass_cnt++;
    do_read(24'h000100, d, v);
    total_cnt++; if (v !== 1'b1 || d !== 12'h000) $display("FAIL past_ram_read: got %h/%b expected 000/1", d, v); else pass_cnt++;
    do_write(24'h000110, 12'h777);
    do_read(24'h000010, d, v);
    total_cnt++; if (d !== 12'h5A5) $display("FAIL unmapped_write_alias: got %h expected 5a5", d); else pass_cnt++;
  endtask

  task automatic test_mask_rw;
    logic [11:0] d; logic v;
    do_write(A_MASK, 12'hABC);
    do_read(A_MASK, d, v);
    total_cnt++; if (d !== 12'hABC || v !== 1'b1) $display("FAIL mask_rw: got %h/%b expected abc/1", d, v); else pass_cnt++;
  endtask

  task automatic test_timer_auto;
    logic [11:0] d; logic v;
    do_write(A_LOAD, 12'h003);
    do_write(A_CTRL, 12'h003);
    do_write(A_MASK, 12'h001);
    total_cnt++; if (irq[0] !== 1'b0) $display("FAIL auto_pre: got %b expected 0", irq[0]); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++; if (irq[0] !== 1'b0) $display("FAIL auto_at_zero: got %b expected 0", irq[0]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (irq !== 24'h000001) $display("FAIL auto_expire1: got %h expected 000001", irq); else pass_cnt++;
    do_write(A_PEND, 12'h001);
    total_cnt++; if (irq[0] !== 1'b0) $display("FAIL auto_w1c: got %b expected 0", irq[0]); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++; if (irq[0] !== 1'b0) $display("FAIL auto_gap: got %b expected 0", irq[0]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (irq[0] !== 1'b1) $display("FAIL auto_expire2: got %b expected 1", irq[0]); else pass_cnt++;
    do_write(A_CTRL, 12'h000);
    do_write(A_PEND, 12'h001);
    do_read(A_COUNT, d, v);
    total_cnt++; if (d !== 12'h003 || v !== 1'b1) $display("FAIL auto_stopped_count: got %h/%b expected 003/1", d, v); else pass_cnt++;
    do_write(A_COUNT, 12'h007);
    do_read(A_COUNT, d, v);
    total_cnt++; if (d !== 12'h003) $display("FAIL count_readonly: got %h expected 003", d); else pass_cnt++;
  endtask

  task automatic test_timer_oneshot;
    logic [11:0] d; logic v;
    do_write(A_LOAD, 12'h002);
    do_write(A_CTRL, 12'h001);
    repeat (2) @(negedge clk);
    total_cnt++; if (irq[0] !== 1'b0) $display("FAIL oneshot_early: got %b expected 0", irq[0]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (irq[0] !== 1'b1) $display("FAIL oneshot_expire: got %b expected 1", irq[0]); else pass_cnt++;
    do_read(A_CTRL, d, v);
    total_cnt++; if (d !== 12'h000) $display("FAIL oneshot_en_cleared: got %h expected 000", d); else pass_cnt++;
    do_read(A_COUNT, d, v);
    total_cnt++; if (d !== 12'h002) $display("FAIL oneshot_count: got %h expected 002", d); else pass_cnt++;
    repeat (4) @(negedge clk);
    do_read(A_COUNT, d, v);
    total_cnt++; if (d !== 12'h002) $display("FAIL oneshot_count_static: got %h expected 002", d); else pass_cnt++;
    do_read(A_PEND, d, v);
    total_cnt++; if (d !== 12'h001) $display("FAIL oneshot_pend_read: got %h expected 001", d); else pass_cnt++;
    do_write(A_PEND, 12'h001);
    total_cnt++; if (irq !== 24'h0) $display("FAIL oneshot_clear: got %h expected 000000", irq); else pass_cnt++;
  endtask

  task automatic test_ext_irq;
    logic [11:0] d; logic v;
    do_write(A_MASK, 12'h002);
    irq_src = 23'h000001;
    do_write(A_PEND, 12'h002);
    total_cnt++; if (irq !== 24'h000002) $display("FAIL ext_set_wins: got %h expected 000002", irq); else pass_cnt++;
    do_write(A_PEND, 12'h002);
    total_cnt++; if (irq !== 24'h000000) $display("FAIL ext_level_no_reset: got %h expected 000000", irq); else pass_cnt++;
    do_read(A_PEND, d, v);
    total_cnt++; if (d !== 12'h000) $display("FAIL ext_pend_read: got %h expected 000", d); else pass_cnt++;
    irq_src = 23'h400001;
    @(negedge clk);
    irq_src = 23'h000000;
    total_cnt++; if (irq !== 24'h800000) $display("FAIL ext_high_bit: got %h expected 800000", irq); else pass_cnt++;
  endtask

  task automatic test_reset_midop;
    logic [11:0] d; logic v;
    do_write(A_LOAD, 12'h005);
    do_write(A_CTRL, 12'h003);
    req = 1'b1; we = 1'b0; address = 24'h000010;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total_cnt++; if (rvalid !== 1'b0 || rdata !== 12'h000) $display("FAIL midop_rst_read: got %h/%b expected 000/0", rdata, rvalid); else pass_cnt++;
    total_cnt++; if (irq !== 24'h0) $display("FAIL midop_rst_irq: got %h expected 000000", irq); else pass_cnt++;
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL midop_no_rvalid: got %b expected 0", rvalid); else pass_cnt++;
    do_read(A_CTRL, d, v);
    total_cnt++; if (d !== 12'h000 || v !== 1'b1) $display("FAIL midop_ctrl: got %h/%b expected 000/1", d, v); else pass_cnt++;
    repeat (3) @(negedge clk);
    do_read(A_COUNT, d, v);
    total_cnt++; if (d !== 12'h000) $display("FAIL midop_count: got %h expected 000", d); else pass_cnt++;
    do_read(A_LOAD, d, v);
    total_cnt++; if (d !== 12'h000) $display("FAIL midop_load: got %h expected 000", d); else pass_cnt++;
    total_cnt++; if (irq !== 24'h0) $display("FAIL midop_timer_idle: got %h expected 000000", irq); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_unmapped();
    test_mask_rw();
    test_timer_auto();
    test_timer_oneshot();
    test_ext_irq();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_target12.md
BUS_TARGET12 -- requirements
Module: bus_target12

Interface
REQ-001 Parameter RAM_WORDS, default 256, number of 12-bit RAM words; power of two, 16..4096.
REQ-002 Parameter IRQ_EXT, default 23, number of external edge-triggered interrupt sources (1..23).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  bus request strobe from the 12-bit processor; one transfer per cycle.
REQ-006 we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 address  input  24  word address of the transfer.
REQ-008 wdata  input  12  write data; qualified by req & we.
REQ-009 rdata  output  12  read data.
REQ-010 rvalid  output  1  high for one cycle when rdata holds the response to a read.
REQ-011 irq_src  input  IRQ_EXT  external interrupt sources; a rising edge sets the pending bit.
REQ-012 irq  output  24  pending & mask; bit 0 = timer, bits 1..IRQ_EXT = irq_src, rest 0.

Function
REQ-013 Address map: 0x000000..RAM_WORDS-1 RAM; 0xFFFF00 TIMER_LOAD; 0xFFFF01 TIMER_CTRL (bit0 EN, bit1 AUTO); 0xFFFF02 IRQ_PEND; 0xFFFF03 IRQ_MASK (bits 11..0 map to irq 11..0); 0xFFFF04 TIMER_COUNT (read-only); all other addresses unmapped.
REQ-014 Read latency is exactly 1 cycle: read accepted at edge N gives rdata/rvalid valid from edge N to edge N+1.
REQ-015 rvalid = 0 in cycles with no read response; rdata holds its last value when rvalid = 0.
REQ-016 Unmapped reads return 12'h000 with rvalid = 1; unmapped writes and writes to TIMER_COUNT are ignored.
REQ-017 IRQ_PEND reads return pending[11:0]; writing 1 clears the bit (W1C), writing 0 has no effect.
REQ-018 Read of a location written in the previous cycle returns the new value; a write and a read never occur in the same cycle.
REQ-019 Timer: when EN = 1 and count != 0, count decrements by 1 per cycle.
REQ-020 When EN = 1 and count = 0: pending[0] set; count <= TIMER_LOAD; EN <= AUTO.
REQ-021 Writing TIMER_LOAD loads both the load register and count in the same edge; that edge performs no decrement.
REQ-022 Writing TIMER_CTRL updates EN and AUTO and leaves count unchanged.
REQ-023 External sources: each irq_src bit is registered once; pending[i+1] is set on a 0->1 transition of the registered value.
REQ-024 A set event and a W1C of the same pending bit in the same cycle: the set wins and the bit stays 1.
REQ-025 irq is combinational from the pending and mask registers; mask bits 23..12 are fixed at 1.

Reset
REQ-026 On rst low, with no clock: rdata = 0; rvalid = 0; pending = 0; IRQ_MASK = 0; TIMER_LOAD = 0; count = 0; EN = AUTO = 0; the irq_src history register = 0; irq = 0.
REQ-027 RAM contents are not reset; a read of unwritten RAM returns an undefined value.
REQ-028 A transfer in flight when reset is asserted is discarded; no rvalid follows reset release.

Structure
REQ-029 Shared package p12_pkg holds the address constants (TIMER_LOAD_ADDR .. TIMER_COUNT_ADDR), the CTRL bit indices and the word width 12 / address width 24.
REQ-030 The timer (REQ-019..022) is a sub-module p12_timer with load/ctrl write strobes, a count output and an expire pulse.
REQ-031 RAM is inferred as synchronous single-port RAM.

Verification
REQ-032 Write 0x5A5 to 0x000010, then read 0x000010 -> next cycle rvalid = 1, rdata = 0x5A5.
REQ-033 Read 0x123456 -> next cycle rvalid = 1, rdata = 0x000; a following idle cycle gives rvalid = 0.
REQ-034 Write TIMER_LOAD = 3, CTRL = 0x3, IRQ_MASK = 0x001 -> pending[0] sets every 4 cycles; irq[0] = 1; W1C 0x001 clears it until the next expiry.
REQ-035 CTRL = 0x1 (one-shot), LOAD = 2 -> single expiry, then EN reads 0 and count = 2 stays constant.
REQ-036 Pulse irq_src[0] 0->1 with mask bit1 = 1 and a W1C of bit1 in the edge-detect cycle -> pending[1] = 1, irq[1] = 1 (set wins).
REQ-037 Assert rst mid-read and mid-countdown -> all outputs 0 immediately; no rvalid after release; timer idle.
